// File: rtl/clk_pkg.sv
// Shared definitions for the clock/reset sequencer.
//   seqState_e : sequencer FSM state encoding (exported on O_State)
//   DEF_*      : default values for the clk_rst_seq parameters
package clk_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOCK = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        SHUTDOWN  = 3'd4,
        ERR       = 3'd5
    } seqState_e;

    localparam int unsigned DEF_NUM_CH        = 4;
    localparam int unsigned DEF_DIV_WIDTH     = 8;
    localparam int unsigned DEF_STAGGER       = 4;
    localparam int unsigned DEF_LOCK_STABLE   = 8;
    localparam int unsigned DEF_LOCK_TO_WIDTH = 12;

endpackage

// File: rtl/clk_div_ch.sv
// Per-channel clock-enable divider.
//   clk, rst_n : system clock, asynchronous active-low reset
//   active     : channel out of reset, enabled and sequencer allows clocks
//   div        : divider value d; one clkEn pulse every d+1 cycles
//   clkEn      : registered clock-enable pulse
module clk_div_ch
#(
    parameter int unsigned DIV_WIDTH = 8
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 active,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 clkEn
);

    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] divLat;

    // divLat only follows div while idle or on the wrap to 0, so a change
    // arriving mid-period takes effect from the next period onward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            divLat <= '0;
            clkEn  <= 1'b0;
        end else begin
            clkEn <= active && (cnt == '0);
            if (!active || (cnt >= divLat)) begin
                cnt    <= '0;
                divLat <= div;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_rst_seq.sv
// Clock/reset sequencer: waits for PLL lock (or bypass), releases channel
// resets one by one, runs per-channel clock-enable dividers, and on
// shutdown or lock loss reasserts the resets in reverse order.
//   I_SysClk, I_SysRst_n : clock, asynchronous active-low reset
//   I_SwClk              : 1 = power up / run, 0 = shut down
//   I_BypPLL             : ignore PLL lock entirely
//   I_PLLLock            : asynchronous PLL lock indication
//   I_ChEn, I_Div        : per-channel clock enable request and divider
//   O_ClkEn, O_ChRst_n   : per-channel clock-enable pulse and reset
//   O_Ready, O_LockErr   : in RUN / sticky lock error
//   O_State              : current FSM state
module clk_rst_seq
    import clk_pkg::*;
#(
    parameter int unsigned NUM_CH        = DEF_NUM_CH,
    parameter int unsigned DIV_WIDTH     = DEF_DIV_WIDTH,
    parameter int unsigned STAGGER       = DEF_STAGGER,
    parameter int unsigned LOCK_STABLE   = DEF_LOCK_STABLE,
    parameter int unsigned LOCK_TO_WIDTH = DEF_LOCK_TO_WIDTH
)(
    input  logic                        I_SysClk,
    input  logic                        I_SysRst_n,
    input  logic                        I_SwClk,
    input  logic                        I_BypPLL,
    input  logic                        I_PLLLock,
    input  logic [NUM_CH-1:0]           I_ChEn,
    input  logic [NUM_CH*DIV_WIDTH-1:0] I_Div,
    output logic [NUM_CH-1:0]           O_ClkEn,
    output logic [NUM_CH-1:0]           O_ChRst_n,
    output logic                        O_Ready,
    output logic                        O_LockErr,
    output logic [2:0]                  O_State
);

    localparam int unsigned IDX_W = $clog2(NUM_CH + 1);
    localparam int unsigned STG_W = $clog2(STAGGER + 1);
    localparam int unsigned STB_W = $clog2(LOCK_STABLE + 1);
    localparam logic [STG_W-1:0] STAG_LAST   = STG_W'(STAGGER - 1);
    localparam logic [STB_W-1:0] STABLE_LAST = STB_W'(LOCK_STABLE - 1);
    localparam logic [IDX_W-1:0] ALL_REL     = IDX_W'(NUM_CH);

    seqState_e                state;
    logic                     rstSettled;
    logic                     lockMeta;
    logic                     lockSync;
    logic [NUM_CH-1:0]        chRstN;
    logic                     ready;
    logic                     lockErr;
    logic [STG_W-1:0]         stagCnt;
    logic [IDX_W-1:0]         relIdx;     // number of channels currently released
    logic [STB_W-1:0]         stableCnt;
    logic [LOCK_TO_WIDTH-1:0] toCnt;
    logic [LOCK_TO_WIDTH-1:0] toInc;
    logic                     allowClk;
    logic [NUM_CH-1:0]        chActive;

    always_ff @(posedge I_SysClk or negedge I_SysRst_n) begin
        if (!I_SysRst_n) begin
            lockMeta <= 1'b0;
            lockSync <= 1'b0;
        end else begin
            lockMeta <= I_PLLLock;
            lockSync <= lockMeta;
        end
    end

    always_comb begin
        toInc = (&toCnt) ? toCnt : toCnt + 1'b1;
    end

    // Clocks are allowed only when this edge keeps the FSM in RELEASE/RUN,
    // so enables drop on the very edge that enters SHUTDOWN.
    always_comb begin
        allowClk = 1'b0;
        if (state == RELEASE) begin
            allowClk = I_SwClk;
        end else if (state == RUN) begin
            allowClk = I_SwClk && (I_BypPLL || lockSync);
        end
        chActive = chRstN & I_ChEn & {NUM_CH{allowClk}};
    end

    // rstSettled delays the first possible transition to the second edge
    // after reset deassertion.
    always_ff @(posedge I_SysClk or negedge I_SysRst_n) begin
        if (!I_SysRst_n) begin
            state      <= IDLE;
            rstSettled <= 1'b0;
            chRstN     <= '0;
            ready      <= 1'b0;
            lockErr    <= 1'b0;
            stagCnt    <= '0;
            relIdx     <= '0;
            stableCnt  <= '0;
            toCnt      <= '0;
        end else if (!rstSettled) begin
            rstSettled <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (I_SwClk) begin
                        stagCnt   <= '0;
                        relIdx    <= '0;
                        stableCnt <= '0;
                        toCnt     <= '0;
                        state     <= I_BypPLL ? RELEASE : WAIT_LOCK;
                    end
                end
                WAIT_LOCK: begin
                    if (!I_SwClk) begin
                        state <= IDLE;
                    end else if (lockSync && (stableCnt == STABLE_LAST)) begin
                        stagCnt <= '0;
                        relIdx  <= '0;
                        state   <= RELEASE;
                    end else if (&toInc) begin
                        lockErr <= 1'b1;
                        state   <= ERR;
                    end else begin
                        toCnt     <= toInc;
                        stableCnt <= lockSync ? stableCnt + 1'b1 : '0;
                    end
                end
                RELEASE: begin
                    if (!I_SwClk) begin
                        stagCnt <= '0;
                        state   <= SHUTDOWN;
                    end else if (relIdx == ALL_REL) begin
                        ready <= 1'b1;
                        state <= RUN;
                    end else if (stagCnt == STAG_LAST) begin
                        stagCnt <= '0;
                        relIdx  <= relIdx + 1'b1;
                        for (int unsigned i = 0; i < NUM_CH; i++) begin
                            if (relIdx == IDX_W'(i)) chRstN[i] <= 1'b1;
                        end
                    end else begin
                        stagCnt <= stagCnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!I_SwClk || (!I_BypPLL && !lockSync)) begin
                        if (I_SwClk) lockErr <= 1'b1;
                        ready   <= 1'b0;
                        stagCnt <= '0;
                        state   <= SHUTDOWN;
                    end
                end
                SHUTDOWN: begin
                    if (relIdx == '0) begin
                        if (!I_SwClk || !lockErr) begin
                            lockErr <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            state <= ERR;
                        end
                    end else if (stagCnt == STAG_LAST) begin
                        stagCnt <= '0;
                        relIdx  <= relIdx - 1'b1;
                        for (int unsigned i = 0; i < NUM_CH; i++) begin
                            if (relIdx == IDX_W'(i + 1)) chRstN[i] <= 1'b0;
                        end
                    end else begin
                        stagCnt <= stagCnt + 1'b1;
                    end
                end
                ERR: begin
                    if (!I_SwClk) begin
                        lockErr <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : gCh
        clk_div_ch #(
            .DIV_WIDTH(DIV_WIDTH)
        ) uDiv (
            .clk   (I_SysClk),
            .rst_n (I_SysRst_n),
            .active(chActive[g]),
            .div   (I_Div[g*DIV_WIDTH +: DIV_WIDTH]),
            .clkEn (O_ClkEn[g])
        );
    end

    assign O_ChRst_n = chRstN;
    assign O_Ready   = ready;
    assign O_LockErr = lockErr;
    assign O_State   = state;

endmodule

// File: tb/tb_clk_rst_seq.sv
module tb_clk_rst_seq;

    localparam int unsigned NCH = 4;
    localparam int unsigned DW  = 8;

    logic             clk = 1'b0;
    logic             rstN;
    logic             swClk;
    logic             bypPll;
    logic             pllLock;
    logic [NCH-1:0]   chEn;
    logic [NCH*DW-1:0] div;
    logic [NCH-1:0]   clkEn;
    logic [NCH-1:0]   chRstN;
    logic             ready;
    logic             lockErr;
    logic [2:0]       state;

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    clk_rst_seq #(
        .NUM_CH(NCH),
        .DIV_WIDTH(DW),
        .STAGGER(4),
        .LOCK_STABLE(8),
        .LOCK_TO_WIDTH(12)
    ) dut (
        .I_SysClk  (clk),
        .I_SysRst_n(rstN),
        .I_SwClk   (swClk),
        .I_BypPLL  (bypPll),
        .I_PLLLock (pllLock),
        .I_ChEn    (chEn),
        .I_Div     (div),
        .O_ClkEn   (clkEn),
        .O_ChRst_n (chRstN),
        .O_Ready   (ready),
        .O_LockErr (lockErr),
        .O_State   (state)
    );

    typedef struct {
        logic        sw;
        logic        byp;
        int unsigned steps;
        logic [2:0]  st;
        logic [3:0]  rst;
        logic [3:0]  ce;
        logic        rdy;
        logic        err;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic checkOut(input string nm, input logic [2:0] st, input logic [3:0] rst,
                            input logic [3:0] ce, input logic rdy, input logic err);
        chk({nm, ".state"}, 32'(state), 32'(st));
        chk({nm, ".chRstN"}, 32'(chRstN), 32'(rst));
        chk({nm, ".clkEn"}, 32'(clkEn), 32'(ce));
        chk({nm, ".ready"}, 32'(ready), 32'(rdy));
        chk({nm, ".lockErr"}, 32'(lockErr), 32'(err));
    endtask

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic runUp();
        bypPll = 1'b1;
        swClk  = 1'b1;
        step(18);
        chk("run_up_state", 32'(state), 32'd3);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[$];
        int          waited;
        bit          enPrev[NCH];
        int unsigned prevDiv[NCH];
        int unsigned nextAt[NCH];
        int unsigned t;
        logic [NCH-1:0] expV;

        // Bypass power-up and orderly shutdown; steps are edges since the previous row.
        tbl.push_back(vec_t'{1'b1, 1'b1, 1, 3'd2, 4'b0000, 4'b0000, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b1, 1'b1, 3, 3'd2, 4'b0000, 4'b0000, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b1, 1'b1, 1, 3'd2, 4'b0001, 4'b0000, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b1, 1'b1, 3, 3'd2, 4'b0001, 4'b0001, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b1, 1'b1, 1, 3'd2, 4'b0011, 4'b0001, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b1, 1'b1, 4, 3'd2, 4'b0111, 4'b0011, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b1, 1'b1, 4, 3'd2, 4'b1111, 4'b0111, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b1, 1'b1, 1, 3'd3, 4'b1111, 4'b1111, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b1, 1'b1, 2, 3'd3, 4'b1111, 4'b1111, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b0, 1'b1, 1, 3'd4, 4'b1111, 4'b0000, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, 1'b1, 3, 3'd4, 4'b1111, 4'b0000, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, 1'b1, 1, 3'd4, 4'b0111, 4'b0000, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, 1'b1, 4, 3'd4, 4'b0011, 4'b0000, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, 1'b1, 4, 3'd4, 4'b0001, 4'b0000, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, 1'b1, 4, 3'd4, 4'b0000, 4'b0000, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, 1'b1, 1, 3'd0, 4'b0000, 4'b0000, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, 1'b1, 2, 3'd0, 4'b0000, 4'b0000, 1'b0, 1'b0});

        rstN = 1'b0; swClk = 1'b0; bypPll = 1'b0; pllLock = 1'b0;
        chEn = '0; div = '0;
        step(3);
        checkOut("reset", 3'd0, 4'h0, 4'h0, 1'b0, 1'b0);
        rstN = 1'b1;
        step(3);
        checkOut("idle", 3'd0, 4'h0, 4'h0, 1'b0, 1'b0);

        chEn = '1;
        div  = '0;
        foreach (tbl[i]) begin
            swClk  = tbl[i].sw;
            bypPll = tbl[i].byp;
            step(tbl[i].steps);
            checkOut($sformatf("tbl%0d", i), tbl[i].st, tbl[i].rst, tbl[i].ce, tbl[i].rdy, tbl[i].err);
        end

        // Lock wait with a glitch, then lock loss in RUN.
        bypPll = 1'b0; pllLock = 1'b0; swClk = 1'b1;
        step(1);
        chk("wait_lock_entry", 32'(state), 32'd1);
        pllLock = 1'b1;
        step(4);
        pllLock = 1'b0;
        step(1);
        chk("wait_lock_glitch", 32'(state), 32'd1);
        pllLock = 1'b1;
        waited = -1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (state == 3'd2) begin
                waited = k;
                break;
            end
        end
        chk("lock_wait_cycles", 32'(waited), 32'd10);
        step(17);
        checkOut("lock_run", 3'd3, 4'b1111, 4'b1111, 1'b1, 1'b0);
        pllLock = 1'b0;
        step(2);
        checkOut("lock_sync_delay", 3'd3, 4'b1111, 4'b1111, 1'b1, 1'b0);
        step(1);
        checkOut("lock_loss", 3'd4, 4'b1111, 4'b0000, 1'b0, 1'b1);
        step(4);
        checkOut("loss_ch3", 3'd4, 4'b0111, 4'b0000, 1'b0, 1'b1);
        step(4);
        chk("loss_ch2", 32'(chRstN), 32'b0011);
        step(4);
        chk("loss_ch1", 32'(chRstN), 32'b0001);
        step(4);
        checkOut("loss_ch0", 3'd4, 4'b0000, 4'b0000, 1'b0, 1'b1);
        step(1);
        checkOut("loss_err", 3'd5, 4'b0000, 4'b0000, 1'b0, 1'b1);
        swClk = 1'b0;
        step(1);
        checkOut("loss_clear", 3'd0, 4'b0000, 4'b0000, 1'b0, 1'b0);

        // Lock timeout: 4095 cycles in WAIT_LOCK.
        swClk = 1'b1;
        step(1);
        chk("to_entry", 32'(state), 32'd1);
        step(4094);
        checkOut("to_before", 3'd1, 4'b0000, 4'b0000, 1'b0, 1'b0);
        step(1);
        checkOut("to_err", 3'd5, 4'b0000, 4'b0000, 1'b0, 1'b1);
        step(3);
        chk("to_err_hold", 32'(state), 32'd5);
        swClk = 1'b0;
        step(1);
        checkOut("to_clear", 3'd0, 4'b0000, 4'b0000, 1'b0, 1'b0);

        // Async reset mid-RELEASE, reset-release latency, abort during RELEASE.
        bypPll = 1'b1; swClk = 1'b1;
        step(9);
        checkOut("pre_rst", 3'd2, 4'b0011, 4'b0001, 1'b0, 1'b0);
        #3;
        rstN = 1'b0;
        #1;
        checkOut("async_rst", 3'd0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        step(1);
        chk("rst_release_edge1", 32'(state), 32'd0);
        step(1);
        chk("rst_release_edge2", 32'(state), 32'd2);
        step(4);
        chk("abort_pre", 32'(chRstN), 32'b0001);
        swClk = 1'b0;
        step(1);
        checkOut("abort_shut", 3'd4, 4'b0001, 4'b0000, 1'b0, 1'b0);
        step(3);
        chk("abort_hold", 32'(chRstN), 32'b0001);
        step(1);
        checkOut("abort_ch0", 3'd4, 4'b0000, 4'b0000, 1'b0, 1'b0);
        step(1);
        chk("abort_idle", 32'(state), 32'd0);

        // Divider: ch0 d=3 then d=1 mid-period, ch1 d=0.
        chEn = '0;
        div  = {8'd1, 8'd2, 8'd0, 8'd3};
        runUp();
        chEn = 4'b0011;
        for (int k = 1; k <= 17; k++) begin
            if (k == 11) div[7:0] = 8'd1;
            step(1);
            chk($sformatf("div_ch0_e%0d", k), 32'(clkEn[0]),
                32'(k inside {1, 5, 9, 13, 15, 17}));
            chk($sformatf("div_ch1_e%0d", k), 32'(clkEn[1]), 32'd1);
        end

        // Randomised enables/dividers in RUN against a period-based model:
        // the period following a pulse uses the divider seen one cycle before it.
        chEn = '0;
        step(1);
        for (int ch = 0; ch < NCH; ch++) begin
            enPrev[ch]  = 1'b0;
            prevDiv[ch] = div[ch*DW +: DW];
            nextAt[ch]  = 0;
        end
        chEn = '1;
        t = 0;
        for (int it = 0; it < 600; it++) begin
            if (it > 0 && $urandom_range(0, 7) == 0) begin
                int idx;
                idx = $urandom_range(0, NCH - 1);
                chEn[idx] = ~chEn[idx];
            end
            if ($urandom_range(0, 3) == 0) begin
                int idx;
                idx = $urandom_range(0, NCH - 1);
                div[idx*DW +: DW] = DW'($urandom_range(0, 6));
            end
            step(1);
            t++;
            for (int ch = 0; ch < NCH; ch++) begin
                expV[ch] = 1'b0;
                if (chEn[ch]) begin
                    if (!enPrev[ch] || t == nextAt[ch]) begin
                        expV[ch]   = 1'b1;
                        nextAt[ch] = t + prevDiv[ch] + 1;
                    end
                end
                enPrev[ch]  = chEn[ch];
                prevDiv[ch] = div[ch*DW +: DW];
            end
            chk($sformatf("rand_clken_%0d", it), 32'(clkEn), 32'(expV));
        end
        chk("rand_state", 32'(state), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/clk_rst_seq.md
CLK_RST_SEQ -- requirements
Module: clk_rst_seq

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of clock/reset channels.
REQ-002 SHALL have parameter DIV_WIDTH, default 8: per-channel divider field width.
REQ-003 SHALL have parameter STAGGER, default 4: cycles between successive channel reset releases.
REQ-004 SHALL have parameter LOCK_STABLE, default 8: consecutive locked cycles required before release.
REQ-005 SHALL have parameter LOCK_TO_WIDTH, default 12: lock-timeout counter width; timeout = 2^LOCK_TO_WIDTH-1 cycles.
REQ-006 SHALL have port I_SysClk, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port I_SysRst_n, input, 1: reset, asynchronous assert, active-low.
REQ-008 SHALL have port I_SwClk, input, 1: synchronous power-up request; 1 = run, 0 = shut down.
REQ-009 SHALL have port I_BypPLL, input, 1: 1 = skip lock wait and lock monitoring.
REQ-010 SHALL have port I_PLLLock, input, 1: asynchronous PLL lock.
REQ-011 SHALL have port I_ChEn, input, NUM_CH: per-channel clock-enable request.
REQ-012 SHALL have port I_Div, input, NUM_CH*DIV_WIDTH: channel i divider in bits [i*DIV_WIDTH +: DIV_WIDTH].
REQ-013 SHALL have port O_ClkEn, output, NUM_CH: per-channel registered clock-enable pulse.
REQ-014 SHALL have port O_ChRst_n, output, NUM_CH: per-channel registered active-low reset.
REQ-015 SHALL have port O_Ready, output, 1: high only in RUN.
REQ-016 SHALL have port O_LockErr, output, 1: lock timeout or lock loss, sticky until I_SwClk=0.
REQ-017 SHALL have port O_State, output, 3: current FSM state encoding.

Function
REQ-018 I_PLLLock SHALL pass a 2-flop synchronizer; all lock decisions use the synchronized value.
REQ-019 FSM states SHALL be IDLE=0, WAIT_LOCK=1, RELEASE=2, RUN=3, SHUTDOWN=4, ERR=5.
REQ-020 IDLE: O_ClkEn=0, O_ChRst_n=0; I_SwClk=1 -> RELEASE if I_BypPLL=1, else WAIT_LOCK with counters cleared.
REQ-021 WAIT_LOCK: LOCK_STABLE consecutive synchronized-lock-high cycles -> RELEASE; any low cycle restarts the stable count; timeout -> ERR; I_SwClk=0 -> IDLE; I_SwClk=0 takes priority.
REQ-022 RELEASE: O_ChRst_n[i] SHALL rise STAGGER*(i+1) cycles after entry; after channel NUM_CH-1 -> RUN next cycle.
REQ-023 RUN: O_Ready=1; I_SwClk=0 -> SHUTDOWN; synchronized lock low while I_BypPLL=0 -> set O_LockErr, go SHUTDOWN.
REQ-024 SHUTDOWN: all O_ClkEn forced 0 from the first SHUTDOWN cycle; O_ChRst_n reasserted in reverse order, channel NUM_CH-1 first, one every STAGGER cycles; after channel 0 -> IDLE if I_SwClk=0, else ERR if O_LockErr=1, else IDLE.
REQ-025 ERR: outputs as IDLE, O_LockErr=1; I_SwClk=0 -> IDLE, clearing O_LockErr.
REQ-026 I_SwClk=0 during RELEASE SHALL enter SHUTDOWN, reasserting only the channels already released, in reverse order.
REQ-027 Divider: channel i counts 0..d (d = latched divider); O_ClkEn[i] <= (O_ChRst_n[i] & I_ChEn[i] & cnt==0), giving 1 pulse per d+1 cycles; d=0 gives O_ClkEn constantly high.
REQ-028 The divider value SHALL be latched only when cnt wraps to 0 or while the channel is disabled, so a mid-period I_Div change never shortens a period.
REQ-029 I_ChEn[i]=0 SHALL hold cnt at 0; the first pulse after re-enable appears 1 cycle after I_ChEn rises.
REQ-030 Counters SHALL saturate and never wrap; the timeout compares at all-ones.

Reset
REQ-031 I_SysRst_n low SHALL asynchronously force IDLE, O_ClkEn=0, O_ChRst_n=0, O_Ready=0, O_LockErr=0, O_State=0, all counters and synchronizer flops 0, at any time including mid-RELEASE/SHUTDOWN.
REQ-032 Reset deassertion SHALL take effect synchronously; the first state change occurs no earlier than the second I_SysClk edge after deassertion.

Structure
REQ-033 State encodings and default parameter constants SHALL live in shared package clk_pkg.
REQ-034 The per-channel divider SHALL be sub-module clk_div_ch, instantiated NUM_CH times by generate.

Verification
REQ-035 Bypass run: I_BypPLL=1, I_SwClk 0->1 -> O_ChRst_n bits rise at +4,+8,+12,+16 cycles; O_Ready at +17.
REQ-036 Lock wait: I_BypPLL=0, lock glitches low at locked cycle 5, then stays high -> RELEASE entered 2 sync + 8 stable cycles after the final rise.
REQ-037 Timeout: lock held 0 -> ERR after 4095 cycles, O_LockErr=1; I_SwClk=0 -> IDLE, O_LockErr=0.
REQ-038 Divider: I_Div ch0=3, ch1=0 in RUN -> ch0 pulses every 4 cycles, ch1 constantly high; change ch0 to 1 mid-period -> current 4-cycle period completes, then every 2 cycles.
REQ-039 Lock loss in RUN -> O_ClkEn all 0 next cycle, resets reassert ch3..ch0 at 4-cycle spacing, ending in ERR.
REQ-040 Async reset mid-RELEASE (after ch1 released) -> all outputs 0 immediately, O_State=0.
